pac_move_scheduler: RTL

//  Once per video frame, decides for every actor (Pacman + ghosts) whether its next step is legal and which direction it takes.

---
 rtl/pac_pkg.sv | 30 +++
 rtl/pac_tile_probe.sv | 55 +++++
 rtl/pac_move_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pac_pkg.sv
// Shared constants and types for the Pacman move scheduler.
//   Direction encodings, sprite/tile geometry, maze size and the
//   scheduler FSM state type.
package pac_pkg;

  localparam int SPRITE_SCALE = 2;
  localparam int SPR          = 16 * SPRITE_SCALE;  // sprite and tile edge in px
  localparam int TILE_SHIFT   = 5;                  // log2(SPR)
  localparam int MAP_COLS     = 20;
  localparam int MAP_ROWS     = 15;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam dir_t INIT_DIR = LEFT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_READ,
    S_WAIT,
    S_DECIDE,
    S_COMMIT
  } state_t;

endpackage

// File: rtl/pac_tile_probe.sv
// Combinational tile probe: given an actor's top-left pixel and a direction,
// computes the pixel just beyond the sprite edge on that side, converts it to
// a tile and returns the maze ROM address of that tile.
//   x, y    : actor top-left, signed 11-bit pixels
//   dir     : direction to probe
//   addr    : row*MAP_COLS+col (meaningless when off_map)
//   off_map : probe lies outside the maze (treated as an open tunnel)
module pac_tile_probe
  import pac_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic signed [10:0] x,
  input  logic signed [10:0] y,
  input  logic [1:0]         dir,
  output logic [ADDR_W-1:0]  addr,
  output logic               off_map
);

  localparam logic signed [10:0] SPR_S  = 11'(SPR);
  localparam logic signed [10:0] HALF_S = 11'(SPR / 2);
  localparam logic signed [10:0] ONE_S  = 11'sd1;
  localparam logic signed [10:0] COLS_S = 11'(MAP_COLS);
  localparam logic signed [10:0] ROWS_S = 11'(MAP_ROWS);

  logic signed [10:0] px, py, col, row;

  always_comb begin
    px = x;
    py = y;
    case (dir)
      UP: begin
        px = x + HALF_S;
        py = y - ONE_S;
      end
      DOWN: begin
        px = x + HALF_S;
        py = y + SPR_S;
      end
      LEFT: begin
        px = x - ONE_S;
        py = y + HALF_S;
      end
      default: begin
        px = x + SPR_S;
        py = y + HALF_S;
      end
    endcase
    col     = px >>> TILE_SHIFT;
    row     = py >>> TILE_SHIFT;
    off_map = col[10] || row[10] || (col >= COLS_S) || (row >= ROWS_S);
    addr    = ADDR_W'(row) * ADDR_W'(MAP_COLS) + ADDR_W'(col);
  end

endmodule

// File: rtl/pac_move_scheduler.sv
// Per-frame move scheduler for Pacman and the ghosts.
// On each frame start it walks all actors through one shared maze-wall ROM
// port, trying the requested direction first and the current direction as a
// fallback, and commits every actor's direction and move enable at once.
//   CLK, RST_N          : clock, async active-low reset
//   X_VGA, Y_VGA        : scan position; (0,0) rising marks frame start
//   REQ_DIR, ACT_X/Y    : per-actor requested direction and top-left position
//   MAP_RD/ADDR/WALL    : wall ROM port, data valid 2 cycles after MAP_RD
//   CUR_DIR, MOVE_EN    : committed direction / step enable per actor
//   BUSY, DONE, OVERRUN : pass in progress, commit pulse, sticky frame overrun
module pac_move_scheduler
  import pac_pkg::*;
#(
  parameter int NUM_ACTORS = 5,
  parameter int ADDR_W     = 9
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic signed [10:0]        X_VGA,
  input  logic signed [10:0]        Y_VGA,
  input  logic [2*NUM_ACTORS-1:0]   REQ_DIR,
  input  logic [11*NUM_ACTORS-1:0]  ACT_X,
  input  logic [11*NUM_ACTORS-1:0]  ACT_Y,
  output logic                      MAP_RD,
  output logic [ADDR_W-1:0]         MAP_ADDR,
  input  logic                      MAP_WALL,
  output logic [2*NUM_ACTORS-1:0]   CUR_DIR,
  output logic [NUM_ACTORS-1:0]     MOVE_EN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      OVERRUN
);

  localparam int IDX_W = (NUM_ACTORS > 1) ? $clog2(NUM_ACTORS) : 1;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic                      fallback;
  logic [1:0]                try_dir;
  logic [2*NUM_ACTORS-1:0]   shadow_dir;
  logic [NUM_ACTORS-1:0]     shadow_en;
  logic                      frame_q;

  logic                      frame_cond, start, last;
  logic signed [10:0]        sel_x, sel_y;
  logic [1:0]                sel_req, sel_cur, sel_dir;
  logic [ADDR_W-1:0]         probe_addr;
  logic                      probe_off;

  assign frame_cond = (X_VGA == 11'sd0) && (Y_VGA == 11'sd0);
  assign start      = frame_cond && !frame_q;
  assign last       = (idx == IDX_W'(NUM_ACTORS - 1));

  // Actor mux feeding the single shared probe
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_req = '0;
    sel_cur = '0;
    for (int unsigned i = 0; i < NUM_ACTORS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_x   = ACT_X[11*i +: 11];
        sel_y   = ACT_Y[11*i +: 11];
        sel_req = REQ_DIR[2*i +: 2];
        sel_cur = CUR_DIR[2*i +: 2];
      end
    end
    sel_dir = fallback ? sel_cur : sel_req;
  end

  pac_tile_probe #(.ADDR_W(ADDR_W)) u_probe (
    .x       (sel_x),
    .y       (sel_y),
    .dir     (sel_dir),
    .addr    (probe_addr),
    .off_map (probe_off)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      idx        <= '0;
      fallback   <= 1'b0;
      try_dir    <= '0;
      shadow_dir <= '0;
      shadow_en  <= '0;
      frame_q    <= 1'b0;
      MAP_RD     <= 1'b0;
      MAP_ADDR   <= '0;
      CUR_DIR    <= {NUM_ACTORS{INIT_DIR}};
      MOVE_EN    <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      frame_q <= frame_cond;
      DONE    <= 1'b0;
      MAP_RD  <= 1'b0;
      if (start && BUSY) OVERRUN <= 1'b1;

      case (state)
        S_IDLE: begin
          BUSY <= 1'b0;
          if (start && !BUSY) begin
            BUSY     <= 1'b1;
            idx      <= '0;
            fallback <= 1'b0;
            state    <= S_CALC;
          end
        end

        // Off-map probes resolve here directly so a tunnel try costs one cycle
        S_CALC: begin
          try_dir <= sel_dir;
          if (probe_off) begin
            shadow_dir[{idx, 1'b0} +: 2] <= sel_dir;
            shadow_en[idx]               <= 1'b1;
            fallback                     <= 1'b0;
            if (last) state <= S_COMMIT;
            else begin
              idx   <= idx + 1'b1;
              state <= S_CALC;
            end
          end else begin
            MAP_ADDR <= probe_addr;
            MAP_RD   <= 1'b1;
            state    <= S_READ;
          end
        end

        S_READ: state <= S_WAIT;

        S_WAIT: state <= S_DECIDE;

        S_DECIDE: begin
          if (MAP_WALL && !fallback && (try_dir != sel_cur)) begin
            fallback <= 1'b1;
            state    <= S_CALC;
          end else begin
            shadow_dir[{idx, 1'b0} +: 2] <= MAP_WALL ? sel_cur : try_dir;
            shadow_en[idx]               <= !MAP_WALL;
            fallback                     <= 1'b0;
            if (last) state <= S_COMMIT;
            else begin
              idx   <= idx + 1'b1;
              state <= S_CALC;
            end
          end
        end

        S_COMMIT: begin
          CUR_DIR <= shadow_dir;
          MOVE_EN <= shadow_en;
          DONE    <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
